// File: rtl/header_stream_if.sv
// rtl/header_stream_if.sv - pixel-beat input and block-header output handshake bundle
interface header_stream_if #(
    parameter int PIXELS_PER_BEAT = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int CHAN_W          = 8,
    parameter int RW_W            = $clog2(CHAN_W + 1)
);
    logic                                        in_valid;
    logic                                        in_ready;
    logic [PIXELS_PER_BEAT*NUM_CHANNELS*CHAN_W-1:0] in_pixels;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [NUM_CHANNELS*CHAN_W-1:0]              out_min;
    logic [NUM_CHANNELS*CHAN_W-1:0]              out_max;
    logic [NUM_CHANNELS*RW_W-1:0]                out_res_w;
    logic                                        out_compressable;

    modport master (
        output in_valid, in_pixels, out_ready,
        input  in_ready, out_valid, out_min, out_max, out_res_w, out_compressable
    );

    modport slave (
        input  in_valid, in_pixels, out_ready,
        output in_ready, out_valid, out_min, out_max, out_res_w, out_compressable
    );
endinterface

// File: rtl/header_stream.sv
// rtl/header_stream.sv - per-block channel min/max, residual width and compressable header generator
module header_stream #(
    parameter int NUM_PIXELS      = 32,
    parameter int PIXELS_PER_BEAT = 8,
    parameter int NUM_CHANNELS    = 4,
    parameter int CHAN_W          = 8,
    parameter int MAX_RES_W       = 4
) (
    input  logic          clk,
    input  logic          rst,
    header_stream_if.slave bus
);
    localparam int BEATS = NUM_PIXELS / PIXELS_PER_BEAT;
    localparam int RW_W  = $clog2(CHAN_W + 1);
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    logic [BC_W-1:0] beat_cnt;
    logic [NUM_CHANNELS-1:0][CHAN_W-1:0] acc_min, acc_max;
    logic [NUM_CHANNELS-1:0][CHAN_W-1:0] beat_min, beat_max;
    logic [NUM_CHANNELS-1:0][CHAN_W-1:0] fold_min, fold_max, rng;
    logic [NUM_CHANNELS-1:0][RW_W-1:0]   res_w;
    logic                                comp;

    logic [NUM_CHANNELS-1:0][CHAN_W-1:0] out_min_q, out_max_q;
    logic [NUM_CHANNELS-1:0][RW_W-1:0]   out_res_w_q;
    logic                                out_valid_q, out_comp_q;

    logic last_beat, accept;

    assign last_beat    = (beat_cnt == LAST_BEAT);
    assign bus.in_ready = !last_beat || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Min/max tree across the beat, then fold with the accumulator and
    // derive the residual width as the index of the top set bit plus one.
    always_comb begin
        comp = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            beat_min[c] = bus.in_pixels[c*CHAN_W +: CHAN_W];
            beat_max[c] = bus.in_pixels[c*CHAN_W +: CHAN_W];
            for (int p = 1; p < PIXELS_PER_BEAT; p++) begin
                if (bus.in_pixels[(p*NUM_CHANNELS+c)*CHAN_W +: CHAN_W] < beat_min[c])
                    beat_min[c] = bus.in_pixels[(p*NUM_CHANNELS+c)*CHAN_W +: CHAN_W];
                if (bus.in_pixels[(p*NUM_CHANNELS+c)*CHAN_W +: CHAN_W] > beat_max[c])
                    beat_max[c] = bus.in_pixels[(p*NUM_CHANNELS+c)*CHAN_W +: CHAN_W];
            end
            if (beat_cnt == '0) begin
                fold_min[c] = beat_min[c];
                fold_max[c] = beat_max[c];
            end else begin
                fold_min[c] = (beat_min[c] < acc_min[c]) ? beat_min[c] : acc_min[c];
                fold_max[c] = (beat_max[c] > acc_max[c]) ? beat_max[c] : acc_max[c];
            end
            rng[c]   = fold_max[c] - fold_min[c];
            res_w[c] = '0;
            for (int i = 0; i < CHAN_W; i++) begin
                if (rng[c][i])
                    res_w[c] = RW_W'(i + 1);
            end
            if (int'(res_w[c]) > MAX_RES_W)
                comp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt    <= '0;
            acc_min     <= '0;
            acc_max     <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            out_res_w_q <= '0;
            out_comp_q  <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                acc_min  <= fold_min;
                acc_max  <= fold_max;
            end
            // A final beat landing in the same cycle as consumption reloads
            // the register and keeps out_valid high, so blocks run bubble-free.
            if (accept && last_beat) begin
                out_valid_q <= 1'b1;
                out_min_q   <= fold_min;
                out_max_q   <= fold_max;
                out_res_w_q <= res_w;
                out_comp_q  <= comp;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid        = out_valid_q;
    assign bus.out_min          = out_min_q;
    assign bus.out_max          = out_max_q;
    assign bus.out_res_w        = out_res_w_q;
    assign bus.out_compressable = out_comp_q;
endmodule
